// File: rtl/chord_cmd_fsm.sv
// Button-chord command decoder: per-button debounce, chord accumulation until full
// release, table lookup to a one-cycle command strobe, optional auto-repeat while held.
module chord_cmd_fsm #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned CMD_W        = 5,
  parameter int unsigned DEBOUNCE_CYC = 250000,
  parameter int unsigned REPEAT_EN    = 0,
  parameter int unsigned REPEAT_DLY   = 25000000,
  parameter int unsigned REPEAT_PER   = 5000000,
  parameter logic [(1<<N_BTN)*CMD_W-1:0] CMD_MAP =
      (((1<<N_BTN)*CMD_W)'(1) << ( 1*CMD_W)) |
      (((1<<N_BTN)*CMD_W)'(2) << ( 2*CMD_W)) |
      (((1<<N_BTN)*CMD_W)'(3) << ( 5*CMD_W)) |
      (((1<<N_BTN)*CMD_W)'(4) << ( 6*CMD_W)) |
      (((1<<N_BTN)*CMD_W)'(5) << ( 9*CMD_W)) |
      (((1<<N_BTN)*CMD_W)'(6) << (10*CMD_W)) |
      (((1<<N_BTN)*CMD_W)'(7) << (13*CMD_W)) |
      (((1<<N_BTN)*CMD_W)'(8) << (14*CMD_W))
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [N_BTN-1:0] iBtns,
  output logic [CMD_W-1:0] oCmd,
  output logic             oCmdValid,
  output logic [N_BTN-1:0] oChord,
  output logic [N_BTN-1:0] oBtnsDb
);

  localparam int unsigned N_MAP = 1 << N_BTN;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC);
  localparam int unsigned S_LIM = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned S_W   = (S_LIM > 1) ? $clog2(S_LIM) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, REPEAT, DRAIN} state_t;

  state_t            state;
  logic [N_BTN-1:0]  sync1, sync2, dbNext;
  logic [DB_W-1:0]   dbCnt [N_BTN];
  logic [S_W-1:0]    scnt;
  logic              dbChg;
  logic [CMD_W-1:0]  cmdTab [N_MAP];
  logic [CMD_W-1:0]  curCmd;

  for (genvar m = 0; m < N_MAP; m++) begin : gMap
    assign cmdTab[m] = CMD_MAP[m*CMD_W +: CMD_W];
  end

  assign curCmd = cmdTab[oChord];

  // Debounced value each bit takes at the coming edge.
  always_comb begin
    dbNext = oBtnsDb;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2[i] != oBtnsDb[i] && dbCnt[i] == DB_W'(DEBOUNCE_CYC-1))
        dbNext[i] = sync2[i];
    end
  end

  assign dbChg = (dbNext != oBtnsDb);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      oBtnsDb <= '0;
      for (int i = 0; i < N_BTN; i++) dbCnt[i] <= '0;
    end else begin
      sync1   <= iBtns;
      sync2   <= sync1;
      oBtnsDb <= dbNext;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == oBtnsDb[i] || dbCnt[i] == DB_W'(DEBOUNCE_CYC-1))
          dbCnt[i] <= '0;
        else
          dbCnt[i] <= dbCnt[i] + 1'b1;
      end
    end
  end

  // Chord FSM; scnt measures cycles since oBtnsDb last changed.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state     <= IDLE;
      oChord    <= '0;
      scnt      <= '0;
      oCmd      <= '0;
      oCmdValid <= 1'b0;
    end else begin
      oCmd      <= '0;
      oCmdValid <= 1'b0;
      if (dbChg)
        scnt <= '0;
      else if (scnt != '1)
        scnt <= scnt + 1'b1;

      case (state)
        IDLE: begin
          if (oBtnsDb != '0) begin
            state  <= ACCUM;
            oChord <= oBtnsDb;
          end
        end
        ACCUM: begin
          oChord <= oChord | oBtnsDb;
          if (oBtnsDb == '0) begin
            oCmd      <= curCmd;
            oCmdValid <= (curCmd != '0);
            oChord    <= '0;
            state     <= IDLE;
          end else if (REPEAT_EN != 0 && oBtnsDb == oChord &&
                       scnt == S_W'(REPEAT_DLY-1)) begin
            oCmd      <= curCmd;
            oCmdValid <= (curCmd != '0);
            scnt      <= '0;
            state     <= REPEAT;
          end
        end
        REPEAT: begin
          if (oBtnsDb != oChord) begin
            state <= DRAIN;
          end else if (scnt == S_W'(REPEAT_PER-1)) begin
            oCmd      <= curCmd;
            oCmdValid <= (curCmd != '0);
            scnt      <= '0;
          end
        end
        DRAIN: begin
          if (oBtnsDb == '0) begin
            oChord <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chord_cmd_fsm.sv
// Directed bench for chord_cmd_fsm: one instance without and one with auto-repeat.
module tb_chord_cmd_fsm;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic [3:0] iBtns = 4'h0;

  logic [4:0] oCmd, rCmd;
  logic       oCmdValid, rCmdValid;
  logic [3:0] oChord, rChord, oBtnsDb, rBtnsDb;

  int nTests = 0;
  int nFail  = 0;

  always #5 iClk = ~iClk;

  chord_cmd_fsm #(.N_BTN(4), .CMD_W(5), .DEBOUNCE_CYC(4), .REPEAT_EN(0),
                  .REPEAT_DLY(8), .REPEAT_PER(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iBtns(iBtns),
    .oCmd(oCmd), .oCmdValid(oCmdValid), .oChord(oChord), .oBtnsDb(oBtnsDb));

  chord_cmd_fsm #(.N_BTN(4), .CMD_W(5), .DEBOUNCE_CYC(4), .REPEAT_EN(1),
                  .REPEAT_DLY(8), .REPEAT_PER(4)) dutR (
    .iClk(iClk), .iRst_n(iRst_n), .iBtns(iBtns),
    .oCmd(rCmd), .oCmdValid(rCmdValid), .oChord(rChord), .oBtnsDb(rBtnsDb));

  // Strobe monitor, sampled just after each rising edge.
  int         cyc = 0;
  int         nStb = 0;
  int         lastCyc = 0;
  logic [4:0] lastCmd = '0;
  logic       leak = 1'b0;
  logic       prevV = 1'b0;
  int         rCyc [$];
  logic [4:0] rCmdQ [$];

  always @(posedge iClk) begin
    #1;
    cyc++;
    if (oCmdValid === 1'b1) begin
      nStb++;
      lastCmd = oCmd;
      lastCyc = cyc;
      if (prevV) leak = 1'b1;
    end else if (oCmd !== 5'd0) begin
      leak = 1'b1;
    end
    prevV = (oCmdValid === 1'b1);
    if (rCmdValid === 1'b1) begin
      rCyc.push_back(cyc);
      rCmdQ.push_back(rCmd);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic waitN(input int n);
    repeat (n) @(negedge iClk);
  endtask

  initial begin
    int         k, s;
    logic [31:0] acc;
    logic       flag;

    // Reset held with all buttons pressed
    iRst_n = 1'b0;
    iBtns  = 4'hF;
    acc    = '0;
    for (int i = 0; i < 10; i++) begin
      waitN(1);
      acc = acc | {oCmd, oCmdValid, oChord, oBtnsDb} | {rCmd, rCmdValid, rChord, rBtnsDb};
    end
    chk("reset_outputs", acc, 0);

    iRst_n = 1'b1;
    waitN(5);
    chk("db_after_rst_c5", oBtnsDb, 4'h0);
    waitN(1);
    chk("db_after_rst_c6", oBtnsDb, 4'hF);
    iBtns = 4'h0;
    waitN(20);
    chk("unmapped_F_nostrobe", nStb, 0);

    // Single press of button 0
    s = nStb;
    iBtns = 4'h1;
    waitN(10);
    chk("press1_chord", oChord, 4'h1);
    waitN(10);
    iBtns = 4'h0;
    k = cyc;
    waitN(15);
    chk("press1_count", nStb - s, 1);
    chk("press1_cmd", lastCmd, 5'd1);
    chk("press1_latency", lastCyc - k, 7);

    // Staggered chord 4 then 5
    s = nStb;
    iBtns = 4'h4;
    k = cyc;
    waitN(5);
    iBtns = 4'h5;
    waitN(3);
    chk("stagger_chord4", oChord, 4'h4);
    waitN(5);
    chk("stagger_chord5", oChord, 4'h5);
    waitN(17);
    iBtns = 4'h0;
    k = cyc;
    waitN(15);
    chk("stagger_count", nStb - s, 1);
    chk("stagger_cmd", lastCmd, 5'd3);
    chk("stagger_latency", lastCyc - k, 7);
    chk("stagger_chord_idle", oChord, 4'h0);

    // Bouncing button 1
    s = nStb;
    acc = '0;
    for (int i = 0; i < 30; i++) begin
      iBtns = (((i / 2) % 2) == 0) ? 4'h2 : 4'h0;
      waitN(1);
      acc = acc | 32'(oBtnsDb);
    end
    iBtns = 4'h0;
    for (int i = 0; i < 10; i++) begin
      waitN(1);
      acc = acc | 32'(oBtnsDb);
    end
    chk("bounce_db", acc, 0);
    chk("bounce_nostrobe", nStb - s, 0);

    // Unmapped chord 3
    iBtns = 4'h3;
    waitN(15);
    chk("unmapped3_chord", oChord, 4'h3);
    waitN(5);
    iBtns = 4'h0;
    waitN(15);
    chk("unmapped3_nostrobe", nStb - s, 0);
    chk("unmapped3_idle", oChord, 4'h0);

    // Auto-repeat: hold D for 42 cycles
    rCyc.delete();
    rCmdQ.delete();
    iBtns = 4'hD;
    k = cyc;
    waitN(6);
    chk("rep_db", rBtnsDb, 4'hD);
    waitN(36);
    iBtns = 4'h0;
    waitN(20);
    chk("rep_count", rCyc.size(), 9);
    if (rCyc.size() == 9) begin
      chk("rep_first", rCyc[0] - k, 14);
      chk("rep_period", rCyc[1] - rCyc[0], 4);
      chk("rep_last", rCyc[8] - k, 46);
    end
    flag = 1'b1;
    foreach (rCmdQ[i]) if (rCmdQ[i] !== 5'd7) flag = 1'b0;
    chk("rep_all_inc", flag, 1'b1);
    chk("rep_idle_chord", rChord, 4'h0);

    // Auto-repeat interrupted by dropping button 0
    rCyc.delete();
    rCmdQ.delete();
    iBtns = 4'hD;
    k = cyc;
    waitN(21);
    iBtns = 4'hC;
    waitN(9);
    chk("drain_chord", rChord, 4'hD);
    waitN(11);
    iBtns = 4'h0;
    waitN(20);
    chk("drop_count", rCyc.size(), 4);
    if (rCyc.size() == 4) chk("drop_last", rCyc[3] - k, 26);
    flag = 1'b1;
    foreach (rCmdQ[i]) if (rCmdQ[i] !== 5'd7) flag = 1'b0;
    chk("drop_no_dec", flag, 1'b1);

    // Reset in the middle of a chord
    s = nStb;
    iBtns = 4'h2;
    waitN(10);
    iRst_n = 1'b0;
    waitN(1);
    iRst_n = 1'b1;
    iBtns = 4'h0;
    chk("midrst_chord", oChord, 4'h0);
    chk("midrst_db", oBtnsDb, 4'h0);
    waitN(15);
    chk("midrst_nostrobe", nStb - s, 0);
    iBtns = 4'h2;
    waitN(10);
    iBtns = 4'h0;
    k = cyc;
    waitN(15);
    chk("post_rst_count", nStb - s, 1);
    chk("post_rst_cmd", lastCmd, 5'd2);
    chk("post_rst_latency", lastCyc - k, 7);

    chk("strobe_hygiene", leak, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/chord_cmd_fsm.md
Name: chord_cmd_fsm

Overview:
Parametrised button-chord command decoder for the stack calculator front panel. It debounces N_BTN raw buttons and accumulates the chord pressed between first press and full release. Each chord is mapped through a parameter table to a microcode command, emitted as a one-cycle strobe to the control unit. An optional auto-repeat mode re-issues the command while a chord is held.

Parameters:
N_BTN, 4, number of buttons (1..6)
CMD_W, 5, command code width
DEBOUNCE_CYC, 250000, stable cycles required before a debounced bit changes (>=2)
REPEAT_EN, 0, 1 enables auto-repeat
REPEAT_DLY, 25000000, held-stable cycles before the first repeat command
REPEAT_PER, 5000000, cycles between subsequent repeat commands
CMD_MAP, see Behaviour, (2**N_BTN)*CMD_W bits; entry m at [m*CMD_W +: CMD_W]

Ports:
iClk  in  1  system clock
iRst_n  in  1  synchronous reset, active low
iBtns  in  N_BTN  raw asynchronous button levels, 1 = pressed
oCmd  out  CMD_W  command code; valid only while oCmdValid=1, else 0
oCmdValid  out  1  one-cycle command strobe
oChord  out  N_BTN  current accumulated chord mask (0 in IDLE)
oBtnsDb  out  N_BTN  debounced button levels

Behaviour:
- Reset (iRst_n=0 at posedge): state IDLE; all outputs 0; sync flops, debounced bits, all counters cleared. Reset mid-chord discards the chord; no command is ever issued for it.
- Debounce, per bit: 2-flop synchroniser, then counter. The counter clears whenever the synced bit equals the debounced bit. Otherwise it increments. On reaching DEBOUNCE_CYC-1 the debounced bit takes the synced value and the counter clears.
- Debounce latency: a clean raw edge appears on oBtnsDb exactly DEBOUNCE_CYC+2 cycles later. A pulse shorter than DEBOUNCE_CYC is filtered.
- FSM operates on db = oBtnsDb. The stable counter (scnt) clears on any db change.
- IDLE: if db!=0, go to ACCUM with mask=db and scnt=0.
- ACCUM:
  - mask <= mask | db each cycle.
  - If db==0: look up cmd=CMD_MAP[mask]. If cmd!=0, assert oCmdValid=1 and oCmd=cmd for one cycle (the cycle after db became 0). Go to IDLE and clear mask.
  - Else if REPEAT_EN, db==mask, and scnt reaches REPEAT_DLY-1: emit CMD_MAP[mask] (if nonzero), go to REPEAT, clear scnt.
- REPEAT:
  - Every REPEAT_PER cycles, emit CMD_MAP[mask] (if nonzero).
  - If db!=mask (any bit released or added), go to DRAIN with no emit.
- DRAIN: wait for db==0, then go to IDLE. No emit, including on release.
- oChord = mask in ACCUM/REPEAT/DRAIN; 0 in IDLE.
- Unmapped chords (entry 0) produce no strobe, but still traverse the FSM normally.
- oCmdValid is never high in two consecutive cycles except when REPEAT_PER=1.
- Counter widths are $clog2 of their limits. Counters saturate rather than wrap.
- Default CMD_MAP (mask -> cmd): 1->1 PSH, 2->2 POP, 5->3 ADD, 6->4 SUB, 9->5 TOP, 10->6 RST, 13->7 INC, 14->8 DEC. All other entries 0.
- Outputs oCmd, oCmdValid, oChord and oBtnsDb are registered.

Test Plan:
(Bench parameters: DEBOUNCE_CYC=4, REPEAT_DLY=8, REPEAT_PER=4.)
- Reset: hold iRst_n=0 while iBtns=4'hF for 10 cycles -> all outputs 0 throughout. After release of reset, oBtnsDb=4'hF at cycle 6.
- Single press: iBtns=4'h1 for 20 cycles, then 0 -> exactly one oCmdValid with oCmd=1, 7 cycles after the falling raw edge. oChord=1 while held.
- Staggered chord: btn2 at t0, btn0 at t0+5, both released at t0+30 -> oChord goes 4 then 5. Exactly one strobe, oCmd=3.
- Bounce filtering: toggle iBtns[1] every 2 cycles for 30 cycles, then hold 0 -> oBtnsDb stays 0 and no strobe. Repeat with unmapped chord 4'h3 held 20 cycles -> oChord=3 and no strobe.
- Auto-repeat (REPEAT_EN=1): hold 4'hD for 40 cycles -> oCmd=7 strobes at db-stable+8, then every 4 cycles. No strobe on release. Dropping btn0 mid-hold (to 4'hC) -> repeats stop, DRAIN is entered, no DEC is issued.
- Mid-chord reset: press 4'h2 for 10 cycles, pulse iRst_n low for 1 cycle, then release -> no strobe. A new 4'h2 press/release -> oCmd=2.
